// File: rtl/tag_chip_pkg.sv
// Shared tag-chip encodings used by both the TX and RX controllers so the two ends agree.
// Holds FSM state codes, GPIO bit positions, the GPIO direction mask and the TX sample-mux select.
package tag_chip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TX    = 2'd2,
        ST_GUARD = 2'd3
    } tag_state_e;

    localparam int SYNC_BIT     = 6;
    localparam int EN_BIT       = 2;
    localparam int TAG_BUSY_BIT = 0;

    localparam logic [11:0] GPIO_DDR_MASK = 12'h044;

    typedef enum logic [1:0] {
        SMP_ZERO = 2'd0,
        SMP_SYNC = 2'd1,
        SMP_PAY  = 2'd2
    } smp_sel_e;

endpackage

// File: rtl/tag_tx_sample_reg.sv
// I/Q output register: muxes preamble / payload / zero into a registered DAC sample with valid and underflow flags.
// One cycle from load controls to outputs; no backpressure, loads every cycle.
module tag_tx_sample_reg
    import tag_chip_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SYNC_AMP   = 16000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  smp_sel_e                     load_sel,
    input  logic                         load_vld,
    input  logic                         load_uf,
    input  logic signed [DATA_WIDTH-1:0] pay_i,
    input  logic signed [DATA_WIDTH-1:0] pay_q,
    output logic signed [DATA_WIDTH-1:0] itx_out,
    output logic signed [DATA_WIDTH-1:0] qtx_out,
    output logic                         tx_valid,
    output logic                         tx_underflow
);

    localparam logic signed [DATA_WIDTH-1:0] AMP_POS = DATA_WIDTH'(SYNC_AMP);
    localparam logic signed [DATA_WIDTH-1:0] AMP_NEG = DATA_WIDTH'(-SYNC_AMP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            itx_out      <= '0;
            qtx_out      <= '0;
            tx_valid     <= 1'b0;
            tx_underflow <= 1'b0;
        end else begin
            tx_valid     <= load_vld;
            tx_underflow <= load_uf;
            case (load_sel)
                SMP_SYNC: begin
                    itx_out <= AMP_POS;
                    qtx_out <= AMP_NEG;
                end
                SMP_PAY: begin
                    itx_out <= pay_i;
                    qtx_out <= pay_q;
                end
                default: begin
                    itx_out <= '0;
                    qtx_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tag_tx_ctrl_tag_chip.sv
// Tag-chip TX controller: GPIO sync/enable handshake plus preamble, payload and guard sample stream toward the DAC.
// Outputs registered one cycle after each transition; payload is pulled only in TX, a missing sample emits 0 and flags underflow.
module tag_tx_ctrl_tag_chip
    import tag_chip_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int SYNC_SIG_N     = 8192,
    parameter int TX_LEN_N       = 4096,
    parameter int GUARD_N        = 256,
    parameter int SYNC_AMP       = 16000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [GPIO_REG_WIDTH-1:0]    fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0]    fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0]    fp_gpio_ddr,
    input  logic signed [DATA_WIDTH-1:0] itx_in,
    input  logic signed [DATA_WIDTH-1:0] qtx_in,
    input  logic                         tx_in_valid,
    output logic                         tx_in_ready,
    output logic signed [DATA_WIDTH-1:0] itx_out,
    output logic signed [DATA_WIDTH-1:0] qtx_out,
    output logic                         tx_valid,
    output logic                         tx_underflow,
    output logic [1:0]                   tx_state,
    output logic [DATA_WIDTH-1:0]        counter_sync
);

    localparam logic [DATA_WIDTH-1:0] SYNC_LAST  = DATA_WIDTH'(SYNC_SIG_N - 1);
    localparam logic [DATA_WIDTH-1:0] TX_LAST    = DATA_WIDTH'(TX_LEN_N - 1);
    localparam logic [DATA_WIDTH-1:0] GUARD_LAST = DATA_WIDTH'(GUARD_N - 1);

    localparam logic [GPIO_REG_WIDTH-1:0] GPIO_SYNC = GPIO_REG_WIDTH'((1 << SYNC_BIT) | (1 << EN_BIT));
    localparam logic [GPIO_REG_WIDTH-1:0] GPIO_EN   = GPIO_REG_WIDTH'(1 << EN_BIT);

    tag_state_e            state;
    logic [DATA_WIDTH-1:0] idx;
    logic                  tag_busy;
    logic                  accept;
    logic                  tx_last;
    smp_sel_e              smp_sel;
    logic                  smp_vld;
    logic                  smp_uf;
    logic                  gpio_in_unused;

    assign tag_busy       = fp_gpio_in[TAG_BUSY_BIT];
    assign gpio_in_unused = ^fp_gpio_in[GPIO_REG_WIDTH-1:1];
    assign tx_in_ready    = (state == ST_TX);
    assign accept         = tx_in_ready & tx_in_valid;
    assign tx_last        = accept && (idx == TX_LAST);
    assign tx_state       = state;
    assign fp_gpio_ddr    = GPIO_REG_WIDTH'(GPIO_DDR_MASK);

    // Sample steering for the edge being decided; an accepted payload sample is always shown,
    // even when the same edge aborts or ends the burst.
    always_comb begin
        smp_sel = SMP_ZERO;
        smp_vld = 1'b0;
        smp_uf  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !tag_busy) begin
                    smp_sel = SMP_SYNC;
                    smp_vld = 1'b1;
                end
            end
            ST_SYNC: begin
                if (!tag_busy) begin
                    smp_vld = 1'b1;
                    if (idx != SYNC_LAST) smp_sel = SMP_SYNC;
                end
            end
            ST_TX: begin
                if (accept) begin
                    smp_sel = SMP_PAY;
                    smp_vld = 1'b1;
                end else if (!tag_busy) begin
                    smp_vld = 1'b1;
                    smp_uf  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            counter_sync <= '0;
            fp_gpio_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx          <= '0;
                    counter_sync <= '0;
                    fp_gpio_out  <= '0;
                    if (start && !tag_busy) begin
                        state       <= ST_SYNC;
                        fp_gpio_out <= GPIO_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (tag_busy) begin
                        state        <= ST_GUARD;
                        idx          <= '0;
                        counter_sync <= '0;
                        fp_gpio_out  <= '0;
                    end else if (idx == SYNC_LAST) begin
                        state        <= ST_TX;
                        idx          <= '0;
                        counter_sync <= '0;
                        fp_gpio_out  <= GPIO_EN;
                    end else begin
                        idx          <= idx + 1'b1;
                        counter_sync <= idx + 1'b1;
                    end
                end
                ST_TX: begin
                    // idx is the next payload index; counter_sync follows the sample on the output
                    if (accept) begin
                        idx          <= idx + 1'b1;
                        counter_sync <= idx;
                    end
                    if (tag_busy || tx_last) begin
                        state        <= ST_GUARD;
                        idx          <= '0;
                        counter_sync <= '0;
                        fp_gpio_out  <= '0;
                    end
                end
                default: begin
                    fp_gpio_out <= '0;
                    if (idx == GUARD_LAST) begin
                        state        <= ST_IDLE;
                        idx          <= '0;
                        counter_sync <= '0;
                    end else begin
                        idx          <= idx + 1'b1;
                        counter_sync <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

    tag_tx_sample_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_AMP   (SYNC_AMP)
    ) u_sample_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_sel     (smp_sel),
        .load_vld     (smp_vld),
        .load_uf      (smp_uf),
        .pay_i        (itx_in),
        .pay_q        (qtx_in),
        .itx_out      (itx_out),
        .qtx_out      (qtx_out),
        .tx_valid     (tx_valid),
        .tx_underflow (tx_underflow)
    );

endmodule

// File: tb/tb_tag_tx_ctrl_tag_chip.sv
// Bench for tag_tx_ctrl_tag_chip: randomized bursts against a burst-level reference model.
// Shortened preamble/payload/guard lengths keep many bursts inside a small cycle budget.
module tb_tag_tx_ctrl_tag_chip;

    localparam int DW      = 16;
    localparam int GW      = 12;
    localparam int SYNC_N  = 120;
    localparam int TX_N    = 40;
    localparam int GUARD_N = 12;
    localparam int AMP     = 16000;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [GW-1:0]        fp_gpio_in;
    logic [GW-1:0]        fp_gpio_out;
    logic [GW-1:0]        fp_gpio_ddr;
    logic signed [DW-1:0] itx_in;
    logic signed [DW-1:0] qtx_in;
    logic                 tx_in_valid;
    logic                 tx_in_ready;
    logic signed [DW-1:0] itx_out;
    logic signed [DW-1:0] qtx_out;
    logic                 tx_valid;
    logic                 tx_underflow;
    logic [1:0]           tx_state;
    logic [DW-1:0]        counter_sync;

    always #5 clk = ~clk;

    tag_tx_ctrl_tag_chip #(
        .DATA_WIDTH     (DW),
        .GPIO_REG_WIDTH (GW),
        .SYNC_SIG_N     (SYNC_N),
        .TX_LEN_N       (TX_N),
        .GUARD_N        (GUARD_N),
        .SYNC_AMP       (AMP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .fp_gpio_in   (fp_gpio_in),
        .fp_gpio_out  (fp_gpio_out),
        .fp_gpio_ddr  (fp_gpio_ddr),
        .itx_in       (itx_in),
        .qtx_in       (qtx_in),
        .tx_in_valid  (tx_in_valid),
        .tx_in_ready  (tx_in_ready),
        .itx_out      (itx_out),
        .qtx_out      (qtx_out),
        .tx_valid     (tx_valid),
        .tx_underflow (tx_underflow),
        .tx_state     (tx_state),
        .counter_sync (counter_sync)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: burst phase (0 idle, 1 preamble, 2 payload, 3 guard), position in phase,
    // index of the last payload sample delivered, and the sample expected on the DAC port.
    int m_ph, m_pos, m_last;
    int e_i, e_q, e_vld, e_uf;
    int pay_k;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic int exp_gpio();
        if (m_ph == 1) return 'h044;
        if (m_ph == 2) return 'h004;
        return 0;
    endfunction

    function automatic int exp_cnt();
        if (m_ph == 1 || m_ph == 3) return m_pos;
        if (m_ph == 2) return m_last;
        return 0;
    endfunction

    task automatic compare_all();
        chk("tx_state", tx_state, m_ph);
        chk("gpio_out", fp_gpio_out, exp_gpio());
        chk("gpio_ddr", fp_gpio_ddr, 'h044);
        chk("in_ready", tx_in_ready, (m_ph == 2));
        chk("itx_out", $signed(itx_out), e_i);
        chk("qtx_out", $signed(qtx_out), e_q);
        chk("tx_valid", tx_valid, e_vld);
        chk("underflow", tx_underflow, e_uf);
        chk("counter", counter_sync, exp_cnt());
    endtask

    task automatic model_reset();
        m_ph = 0; m_pos = 0; m_last = 0;
        e_i = 0; e_q = 0; e_vld = 0; e_uf = 0;
    endtask

    task automatic model_step(input bit st, input bit busy, input bit vld, input int pi, input int pq);
        e_i = 0; e_q = 0; e_vld = 0; e_uf = 0;
        case (m_ph)
            0: if (st && !busy) begin
                m_ph = 1; m_pos = 0; e_vld = 1; e_i = AMP; e_q = -AMP;
            end
            1: if (busy) begin
                m_ph = 3; m_pos = 0;
            end else if (m_pos == SYNC_N - 1) begin
                m_ph = 2; m_pos = 0; m_last = 0; e_vld = 1;
            end else begin
                m_pos++; e_vld = 1; e_i = AMP; e_q = -AMP;
            end
            2: begin
                if (vld) begin
                    e_i = pi; e_q = pq; e_vld = 1; m_last = m_pos; m_pos++;
                end
                if (busy || m_pos == TX_N) begin
                    m_ph = 3; m_pos = 0;
                end else if (!vld) begin
                    e_vld = 1; e_uf = 1;
                end
            end
            default: if (m_pos == GUARD_N - 1) begin
                m_ph = 0; m_pos = 0;
            end else begin
                m_pos++;
            end
        endcase
    endtask

    // One clock: check what the last edge produced, then drive the inputs for the next edge.
    task automatic step(input bit st, input bit busy, input bit vld);
        bit acc;
        @(negedge clk);
        compare_all();
        start       = st;
        fp_gpio_in  = {11'($urandom), busy};
        tx_in_valid = vld;
        if (vld) begin
            itx_in = DW'(pay_k);
            qtx_in = DW'(-pay_k);
        end else begin
            itx_in = DW'($urandom);
            qtx_in = DW'($urandom);
        end
        acc = (m_ph == 2) && vld;
        model_step(st, busy, vld, pay_k, -pay_k);
        if (acc) pay_k++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_all();
        start = 1'b0; tx_in_valid = 1'b0; fp_gpio_in = '0;
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        reset_n = 1'b1;
    endtask

    task automatic finish_burst(input int vld_pct, input int busy_pmil, input bit start_in_guard);
        for (int n = 0; n < 5000 && m_ph != 0; n++)
            step((start_in_guard && m_ph == 3) || ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 999) < busy_pmil),
                 ($urandom_range(0, 99) < vld_pct));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; fp_gpio_in = '0; tx_in_valid = 1'b0;
        itx_in = '0; qtx_in = '0; pay_k = 0;
        model_reset();
        #1 compare_all();
        #99 reset_n = 1'b1;

        // Idle after reset with no start
        repeat (5) step(0, 0, 0);

        // Full burst, source always valid
        step(1, 0, 1);
        finish_burst(100, 0, 0);

        // Ten-cycle payload gap in the middle of TX
        step(1, 0, 1);
        for (int n = 0; n < 1000 && !(m_ph == 2 && m_pos == 20); n++) step(0, 0, 1);
        repeat (10) step(0, 0, 0);
        finish_burst(100, 0, 0);

        // Abort at preamble count 100, starts during guard ignored
        step(1, 0, 1);
        for (int n = 0; n < 1000 && !(m_ph == 1 && m_pos == 100); n++) step(0, 0, 1);
        step(0, 1, 1);
        for (int n = 0; n < 1000 && m_ph != 0; n++) step(1, 0, 1);

        // Start while tag busy is ignored
        repeat (3) step(1, 1, 1);
        repeat (2) step(0, 0, 0);

        // Asynchronous reset mid-TX, then a clean full burst
        step(1, 0, 1);
        for (int n = 0; n < 1000 && !(m_ph == 2 && m_pos == 10); n++) step(0, 0, 1);
        do_reset();
        step(0, 0, 0);
        step(1, 0, 1);
        finish_burst(100, 0, 0);

        // Back-to-back: start on the first idle cycle after guard
        step(1, 0, 1);
        finish_burst(100, 0, 0);
        step(1, 0, 1);
        finish_burst(90, 0, 0);

        // Randomized bursts with gaps, aborts and stray starts
        for (int b = 0; b < 12; b++) begin
            step(1, 0, 1);
            finish_burst(70, 4, 1);
            repeat ($urandom_range(0, 3)) step($urandom_range(0, 1), 1, 0);
        end
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_tx_ctrl_tag_chip.md
Name: tag_tx_ctrl_tag_chip

Overview:
Transmit-side counterpart of the tag-chip RX controller. It drives the tag-chip GPIO handshake (sync, then enable) and emits a registered I/Q sample stream toward the DAC path. Each burst is a constant sync preamble of SYNC_SIG_N samples, a payload of TX_LEN_N samples taken from an upstream valid/ready source, and a guard interval. It sits between the payload generator and the radio TX datapath; GPIO lines go to the tag chip.

Parameters:
DATA_WIDTH, 16, I/Q sample width and counter_sync width
GPIO_REG_WIDTH, 12, front-panel GPIO width
SYNC_SIG_N, 8192, preamble length in samples (1..2^DATA_WIDTH)
TX_LEN_N, 4096, payload samples per burst (>=1)
GUARD_N, 256, guard cycles after a burst (>=1)
SYNC_AMP, 16000, preamble amplitude (signed)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle burst request
fp_gpio_in  in  GPIO_REG_WIDTH  tag-chip status; bit0 = TAG_BUSY (abort)
fp_gpio_out  out  GPIO_REG_WIDTH  handshake to tag chip; bit6 = SYNC, bit2 = EN
fp_gpio_ddr  out  GPIO_REG_WIDTH  direction mask
itx_in, qtx_in  in  DATA_WIDTH each  payload samples, signed
tx_in_valid  in  1  payload sample valid
tx_in_ready  out  1  payload sample accepted when valid&ready
itx_out, qtx_out  out  DATA_WIDTH each  registered TX samples
tx_valid  out  1  itx_out/qtx_out hold a sample
tx_underflow  out  1  one-cycle pulse: payload sample missing in TX
tx_state  out  2  0 IDLE, 1 SYNC, 2 TX, 3 GUARD
counter_sync  out  DATA_WIDTH  current preamble/payload/guard index

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all outputs 0 except fp_gpio_ddr = 12'h044. fp_gpio_ddr is constant 12'h044 at all times.
- All outputs are registered. A state's outputs appear in the cycle after the transition edge.
- IDLE:
  - fp_gpio_out = 0, tx_valid = 0, tx_in_ready = 0, samples = 0.
  - start=1 and TAG_BUSY=0 -> SYNC with counter = 0.
  - start=1 with TAG_BUSY=1 is ignored.
- SYNC:
  - fp_gpio_out = 12'h044, itx_out = +SYNC_AMP, qtx_out = -SYNC_AMP, tx_valid = 1.
  - counter_sync runs 0..SYNC_SIG_N-1, one per cycle.
  - At SYNC_SIG_N-1 -> TX with counter = 0.
- TX:
  - fp_gpio_out = 12'h004; tx_in_ready = 1 combinationally while in TX.
  - Accepted sample is registered to itx_out/qtx_out next cycle, tx_valid = 1, counter += 1.
  - tx_in_valid = 0: output 0/0 with tx_valid = 1 (continuous DAC stream), tx_underflow pulses, counter does not advance.
  - Acceptance of sample TX_LEN_N-1 -> GUARD. counter_sync shows the index of the last accepted sample.
- GUARD:
  - fp_gpio_out = 0, tx_valid = 0, samples = 0, tx_in_ready = 0.
  - counter runs 0..GUARD_N-1, then -> IDLE.
- Abort: TAG_BUSY=1 in SYNC or TX -> GUARD next cycle, counter = 0.
  - If the last payload acceptance coincides with abort, that sample is still output and the state still goes to GUARD.
- start outside IDLE is ignored, including during GUARD.
- Counter is DATA_WIDTH bits, no wrap within a legal parameter set. counter_sync reads 0 in IDLE.
- Asynchronous reset mid-burst returns to IDLE immediately, GPIO outputs 0, and any in-flight sample is dropped.

Decomposition:
- Shared package tag_chip_pkg holds:
  - state encodings ST_IDLE..ST_GUARD
  - GPIO bit indices SYNC_BIT=6, EN_BIT=2, TAG_BUSY_BIT=0
  - GPIO_DDR_MASK = 12'h044
  - The same encodings are imported by the RX controller so both ends agree.
- One sub-module: tag_tx_sample_reg, the I/Q output register with mux (preamble / payload / zero) and the valid/underflow flags. The FSM and counter stay in the top.

Test Plan:
1. Reset held 100 time units, then released with no start -> tx_state = 0, fp_gpio_out = 12'h000, fp_gpio_ddr = 12'h044, tx_valid = 0 throughout.
2. start pulse, payload source always valid with ramp I=k, Q=-k -> 8192 cycles of fp_gpio_out = 12'h044 and 16000/-16000; then 4096 samples 0..4095 on itx_out with gpio = 12'h004; then 256 cycles of gpio 0; then tx_state = 0.
3. Payload valid deasserted for 10 cycles mid-TX -> 10 zero samples, 10 tx_underflow pulses, burst ends 10 cycles later, all 4096 samples delivered in order.
4. fp_gpio_in = 12'h001 asserted at SYNC count 100 -> GUARD next cycle, gpio 0, tx_valid 0, IDLE after 256 cycles. A start during GUARD is ignored.
5. start with fp_gpio_in = 12'h001 in IDLE -> remains IDLE. Also: reset_n dropped mid-TX -> all outputs reset asynchronously, and a subsequent start runs a full burst.
6. Back-to-back: start asserted on the first IDLE cycle after GUARD -> new SYNC begins, counter_sync restarts at 0.
